rnd_server: RTL

- Random-number server: shares one free-running 16-bit LFSR word among N_REQ game-logic requesters (spawners, AI, effects).
- Round-robin arbitration between requesters.
- Each requester gets a uniformly distributed value in [0, limit) via mask-and-reject sampling.
- Sits on the pixel clock next to the LFSR; output ordering is deterministic from reset.

---
 rtl/rnd_server_pkg.sv | 35 +++
 rtl/rnd_server_rr_pick.sv | 31 +++
 rtl/rnd_server.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rnd_server_pkg.sv
// rnd_server_pkg: shared constants, state encoding and the limit-to-mask helper
// for the random-number server.
// Optional build macro RND_WHITEN_EN (used by rnd_server) XORs the high byte
// of the LFSR word into the candidate before masking.
package rnd_server_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_OUT_W     = 8;
    localparam int DEF_MAX_TRIES = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAW    = 2'd1,
        ST_DELIVER = 2'd2
    } state_e;

    // Smallest all-ones mask covering lim-1; lim == 0 stands for 2^out_w and
    // therefore yields every bit of the delivered width.
    function automatic logic [7:0] mask_from_limit(input logic [7:0] lim,
                                                   input int unsigned out_w);
        logic [7:0] smear_v;
        logic [7:0] width_v;
        width_v = 8'hFF >> (32'd8 - out_w);
        if (lim == 8'd0) begin
            smear_v = 8'hFF;
        end else begin
            smear_v = lim - 8'd1;
            smear_v = smear_v | (smear_v >> 1);
            smear_v = smear_v | (smear_v >> 2);
            smear_v = smear_v | (smear_v >> 4);
        end
        return smear_v & width_v;
    endfunction

endpackage

// File: rtl/rnd_server_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first set request
// bit at or after ptr, wrapping around, plus a flag that any bit was set.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the farthest offset back to ptr so the nearest request wins.
    always_comb begin
        int k_v;
        k_v   = 0;
        idx   = '0;
        valid = 1'b0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            k_v = (int'(ptr) + off) % N_REQ;
            if (req[k_v]) begin
                idx   = IDX_W'(k_v);
                valid = 1'b1;
            end else begin
                idx   = idx;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/rnd_server.sv
// rnd_server: shares one free-running LFSR word among N_REQ requesters.
// Round-robin grant, then mask-and-reject sampling into [0, limit); after
// MAX_TRIES rejects a value forced below the limit is delivered instead.
// Build macro RND_WHITEN_EN: candidate = low bits XOR high bits of rnd_in.
module rnd_server
    import rnd_server_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int MAX_TRIES = DEF_MAX_TRIES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            rnd_in,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*OUT_W-1:0] limit,
    output logic [N_REQ-1:0]       ack,
    output logic [OUT_W-1:0]       value,
    output logic                   busy
);

    localparam int               IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0]       LAST_TRY  = 4'(MAX_TRIES - 1);
    localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

    state_e             state_r;
    logic [IDX_W-1:0]   grant_r;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [OUT_W-1:0]   lim_r;
    logic [OUT_W-1:0]   mask_r;
    logic [OUT_W-1:0]   value_r;
    logic [3:0]         try_r;
    logic [N_REQ-1:0]   ack_r;
    logic               busy_r;

    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_vld_s;
    logic [OUT_W-1:0]   lim_slice_s;
    logic [7:0]         mask_full_s;
    logic [OUT_W-1:0]   mask_s;
    logic [OUT_W-1:0]   raw_s;
    logic [OUT_W-1:0]   cand_s;
    logic               accept_s;
    logic [IDX_W-1:0]   rr_next_s;
    logic               unused_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_r),
        .idx   (pick_idx_s),
        .valid (pick_vld_s)
    );

    assign lim_slice_s = limit[int'(pick_idx_s)*OUT_W +: OUT_W];
    assign mask_full_s = mask_from_limit(8'(lim_slice_s), OUT_W);
    assign mask_s      = mask_full_s[OUT_W-1:0];

`ifdef RND_WHITEN_EN
    assign raw_s = rnd_in[OUT_W-1:0] ^ rnd_in[15 -: OUT_W];
`else
    assign raw_s = rnd_in[OUT_W-1:0];
`endif
    // Upper LFSR bits are consumed only by the whitened build.
    assign unused_s = ^rnd_in;

    assign cand_s   = raw_s & mask_r;
    assign accept_s = (lim_r == '0) || (cand_s < lim_r);

    // Pointer moves one past the requester that was just served.
    always_comb begin
        if (grant_r == IDX_W'(N_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_r + IDX_W'(1);
        end
    end

    // Grant / draw / deliver sequencer with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            rr_ptr_r <= '0;
            lim_r    <= '0;
            mask_r   <= '0;
            value_r  <= '0;
            try_r    <= 4'd0;
            ack_r    <= '0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= '0;
                    if (pick_vld_s) begin
                        grant_r <= pick_idx_s;
                        lim_r   <= lim_slice_s;
                        mask_r  <= mask_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_DRAW;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_DRAW: begin
                    if (!req[grant_r]) begin
                        // Requester withdrew: drop the draw silently.
                        try_r   <= 4'd0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (accept_s) begin
                        value_r <= cand_s;
                        ack_r   <= ONE_HOT_0 << grant_r;
                        state_r <= ST_DELIVER;
                    end else if (try_r == LAST_TRY) begin
                        // Dropping the top mask bit guarantees a value below lim.
                        value_r <= cand_s & (mask_r >> 1);
                        ack_r   <= ONE_HOT_0 << grant_r;
                        state_r <= ST_DELIVER;
                    end else begin
                        try_r   <= try_r + 4'd1;
                        state_r <= ST_DRAW;
                    end
                end
                ST_DELIVER: begin
                    ack_r    <= '0;
                    rr_ptr_r <= rr_next_s;
                    try_r    <= 4'd0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    ack_r   <= '0;
                    try_r   <= 4'd0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack   = ack_r;
    assign value = value_r;
    assign busy  = busy_r;

endmodule
